// File: rtl/fetch_stage.sv
// Purpose : MIPS instruction-fetch stage with fetch PC, next-PC selection, AdEL detection and the IF/ID register.
// Latency : zero-cycle instruction memory, so the word fetched at PC_F lands in the D registers on the same edge.
// Backpressure: stall freezes PC_F and every D register; Req overrides stall and redirects to the handler.
//
// Ports:
//   clk, reset         clock and asynchronous active-high reset
//   Req                exception/interrupt taken, redirect to HANDLER_PC and flush D
//   stall              hold PC_F and the IF/ID register
//   eret_D, EPC        ERET in decode and its return address; the word fetched behind it is squashed
//   npc_sel, npc_target branch taken / jump in decode and its target
//   jb_D               decode holds a branch/jump, so the current fetch is a delay slot
//   i_inst_rdata       instruction word read combinationally at i_inst_addr
//   i_inst_addr        current fetch PC
//   Instr_D, PC_D, ExcCode_D, BD_D  registered IF/ID contents for the decode splitter
module fetch_stage #(
   parameter logic [31:0] PC_RESET   = 32'h0000_3000,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] IM_LO      = 32'h0000_3000,
   parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Req,
   input  logic        stall,
   input  logic        eret_D,
   input  logic [31:0] EPC,
   input  logic        npc_sel,
   input  logic [31:0] npc_target,
   input  logic        jb_D,
   input  logic [31:0] i_inst_rdata,
   output logic [31:0] i_inst_addr,
   output logic [31:0] Instr_D,
   output logic [31:0] PC_D,
   output logic [4:0]  ExcCode_D,
   output logic        BD_D
);

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;

   logic [31:0] pc_f;
   logic        adel_f;
   logic [31:0] instr_f;
   logic [4:0]  exc_f;

   assign i_inst_addr = pc_f;

   // Misaligned or outside the instruction window; unsigned compares.
   assign adel_f  = (pc_f[1:0] != 2'b00) || (pc_f < IM_LO) || (pc_f > IM_HI);
   // A faulting fetch is turned into a nop that carries the AdEL code.
   assign instr_f = adel_f ? 32'h0 : i_inst_rdata;
   assign exc_f   = adel_f ? EXC_ADEL : EXC_NONE;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_f      <= PC_RESET;
         Instr_D   <= 32'h0;
         PC_D      <= PC_RESET;
         ExcCode_D <= EXC_NONE;
         BD_D      <= 1'b0;
      end else if (Req) begin
         // Exception entry wins over everything, including stall.
         pc_f      <= HANDLER_PC;
         Instr_D   <= 32'h0;
         PC_D      <= HANDLER_PC;
         ExcCode_D <= EXC_NONE;
         BD_D      <= 1'b0;
      end else if (!stall) begin
         if (eret_D) begin
            // ERET has no delay slot: squash the word fetched behind it.
            pc_f      <= EPC;
            Instr_D   <= 32'h0;
            PC_D      <= pc_f;
            ExcCode_D <= EXC_NONE;
            BD_D      <= 1'b0;
         end else begin
            // Taken or not, the fetch behind a branch/jump is its delay slot;
            // npc_sel implies jb_D so BD is forced on for the taken case.
            pc_f      <= npc_sel ? npc_target : pc_f + 32'd4;
            Instr_D   <= instr_f;
            PC_D      <= pc_f;
            ExcCode_D <= exc_f;
            BD_D      <= jb_D | npc_sel;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        Req = 1'b0;
   logic        stall = 1'b0;
   logic        eret_D = 1'b0;
   logic [31:0] EPC = 32'h0;
   logic        npc_sel = 1'b0;
   logic [31:0] npc_target = 32'h0;
   logic        jb_D = 1'b0;
   logic [31:0] i_inst_rdata = 32'h0;
   logic [31:0] i_inst_addr;
   logic [31:0] Instr_D;
   logic [31:0] PC_D;
   logic [4:0]  ExcCode_D;
   logic        BD_D;

   fetch_stage dut (
      .clk         (clk),
      .reset       (reset),
      .Req         (Req),
      .stall       (stall),
      .eret_D      (eret_D),
      .EPC         (EPC),
      .npc_sel     (npc_sel),
      .npc_target  (npc_target),
      .jb_D        (jb_D),
      .i_inst_rdata(i_inst_rdata),
      .i_inst_addr (i_inst_addr),
      .Instr_D     (Instr_D),
      .PC_D        (PC_D),
      .ExcCode_D   (ExcCode_D),
      .BD_D        (BD_D)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        req;
      logic        stl;
      logic        eret;
      logic [31:0] epc;
      logic        nsel;
      logic [31:0] tgt;
      logic        jb;
      logic [31:0] rdata;
      logic [31:0] e_pcf;
      logic [31:0] e_instr;
      logic [31:0] e_pcd;
      logic [4:0]  e_exc;
      logic        e_bd;
   } vec_t;

   typedef struct {
      string       tag;
      logic [31:0] pcf;
      logic [31:0] instr;
      logic [31:0] pcd;
      logic [4:0]  exc;
      logic        bd;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic compare_outputs(input exp_t e);
      chk({e.tag, " i_inst_addr"}, i_inst_addr, e.pcf);
      chk({e.tag, " Instr_D"},     Instr_D,     e.instr);
      chk({e.tag, " PC_D"},        PC_D,        e.pcd);
      chk({e.tag, " ExcCode_D"},   {27'h0, ExcCode_D}, {27'h0, e.exc});
      chk({e.tag, " BD_D"},        {31'h0, BD_D},      {31'h0, e.bd});
   endtask

   // Drive one vector at the falling edge, push its expectation, then pop and
   // compare just after the rising edge that consumes it.
   task automatic apply(input string tag, input vec_t v);
      exp_t e;
      @(negedge clk);
      reset        = 1'b0;
      Req          = v.req;
      stall        = v.stl;
      eret_D       = v.eret;
      EPC          = v.epc;
      npc_sel      = v.nsel;
      npc_target   = v.tgt;
      jb_D         = v.jb;
      i_inst_rdata = v.rdata;
      e.tag = tag; e.pcf = v.e_pcf; e.instr = v.e_instr;
      e.pcd = v.e_pcd; e.exc = v.e_exc; e.bd = v.e_bd;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s scoreboard: got empty queue, expected one entry", tag);
      end else begin
         compare_outputs(sb_q.pop_front());
      end
   endtask

   localparam int NV = 25;
   vec_t tbl [NV];

   initial begin
      exp_t rst_e;
      vec_t v;

      //            req stl eret epc           nsel tgt           jb rdata          e_pcf         e_instr       e_pcd         exc  bd
      tbl[0]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h2401_0001, 32'h0000_3004,32'h2401_0001,32'h0000_3000,5'd0,1'b0};
      tbl[1]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h2402_0002, 32'h0000_3008,32'h2402_0002,32'h0000_3004,5'd0,1'b0};
      tbl[2]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h2403_0003, 32'h0000_3008,32'h2402_0002,32'h0000_3004,5'd0,1'b0};
      tbl[3]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h2403_0003, 32'h0000_3008,32'h2402_0002,32'h0000_3004,5'd0,1'b0};
      tbl[4]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h2403_0003, 32'h0000_300C,32'h2403_0003,32'h0000_3008,5'd0,1'b0};
      tbl[5]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h1000_0004, 32'h0000_3010,32'h1000_0004,32'h0000_300C,5'd0,1'b0};
      tbl[6]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_3100,1'b1,32'h0000_1025, 32'h0000_3100,32'h0000_1025,32'h0000_3010,5'd0,1'b1};
      tbl[7]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h2404_0004, 32'h0000_3104,32'h2404_0004,32'h0000_3100,5'd0,1'b0};
      tbl[8]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_3102,1'b1,32'h2405_0005, 32'h0000_3102,32'h2405_0005,32'h0000_3104,5'd0,1'b1};
      tbl[9]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'hDEAD_BEEF, 32'h0000_3106,32'h0000_0000,32'h0000_3102,5'd4,1'b0};
      tbl[10] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_7000,1'b1,32'hCAFE_F00D, 32'h0000_7000,32'h0000_0000,32'h0000_3106,5'd4,1'b1};
      tbl[11] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h1234_5678, 32'h0000_7004,32'h0000_0000,32'h0000_7000,5'd4,1'b0};
      tbl[12] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_6FFC,1'b1,32'h1111_1111, 32'h0000_6FFC,32'h0000_0000,32'h0000_7004,5'd4,1'b1};
      tbl[13] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h2222_2222, 32'h0000_7000,32'h2222_2222,32'h0000_6FFC,5'd0,1'b0};
      tbl[14] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_2FFC,1'b1,32'h3333_3333, 32'h0000_2FFC,32'h0000_0000,32'h0000_7000,5'd4,1'b1};
      tbl[15] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h4444_4444, 32'h0000_3000,32'h0000_0000,32'h0000_2FFC,5'd4,1'b0};
      tbl[16] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_3020,1'b1,32'h5555_5555, 32'h0000_3020,32'h5555_5555,32'h0000_3000,5'd0,1'b1};
      tbl[17] = '{1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h6666_6666, 32'h0000_4180,32'h0000_0000,32'h0000_4180,5'd0,1'b0};
      tbl[18] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h7777_7777, 32'h0000_4184,32'h7777_7777,32'h0000_4180,5'd0,1'b0};
      tbl[19] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h4200_0018, 32'h0000_4188,32'h4200_0018,32'h0000_4184,5'd0,1'b0};
      tbl[20] = '{1'b0,1'b0,1'b1,32'h0000_3040,1'b0,32'h0,        1'b0,32'h8888_8888, 32'h0000_3040,32'h0000_0000,32'h0000_4188,5'd0,1'b0};
      tbl[21] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'hFFFF_FFFC,1'b1,32'h9999_9999, 32'hFFFF_FFFC,32'h9999_9999,32'h0000_3040,5'd0,1'b1};
      tbl[22] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'hAAAA_AAAA, 32'h0000_0000,32'h0000_0000,32'hFFFF_FFFC,5'd4,1'b0};
      tbl[23] = '{1'b0,1'b1,1'b1,32'h0000_3000,1'b0,32'h0,        1'b0,32'hAAAA_AAAA, 32'h0000_0000,32'h0000_0000,32'hFFFF_FFFC,5'd4,1'b0};
      tbl[24] = '{1'b0,1'b0,1'b1,32'h0000_3000,1'b0,32'h0,        1'b0,32'hAAAA_AAAA, 32'h0000_3000,32'h0000_0000,32'h0000_0000,5'd0,1'b0};

      rst_e.pcf = 32'h0000_3000; rst_e.instr = 32'h0; rst_e.pcd = 32'h0000_3000;
      rst_e.exc = 5'd0; rst_e.bd = 1'b0;

      // Power-on reset, checked while reset is still high.
      #1 reset = 1'b1;
      #2;
      rst_e.tag = "reset";
      compare_outputs(rst_e);
      @(posedge clk);
      @(posedge clk);

      for (int i = 0; i < NV; i++)
         apply($sformatf("v%0d", i), tbl[i]);

      // Move away from reset values, then hit reset mid-cycle during a stall.
      v = '{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'hBBBB_BBBB,
            32'h0000_3004,32'hBBBB_BBBB,32'h0000_3000,5'd0,1'b0};
      apply("pre_rst", v);
      @(negedge clk);
      stall = 1'b1;
      #2 reset = 1'b1;
      #1;
      rst_e.tag = "mid_rst";
      compare_outputs(rst_e);

      // Reset held through an edge, then released: fetch restarts at PC_RESET.
      v = '{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h2401_0001,
            32'h0000_3004,32'h2401_0001,32'h0000_3000,5'd0,1'b0};
      apply("post_rst", v);

      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard drain: got %0d entries, expected 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core, directly upstream of the decode-stage field splitter.
- Owns the fetch PC and next-PC selection, and drives the instruction-memory address.
- Detects fetch-address exceptions (AdEL).
- Holds the IF/ID pipeline register whose instruction word the splitter consumes, with stall, bubble and exception-redirect control.

Parameters:
- PC_RESET, 32'h0000_3000, fetch PC after reset.
- HANDLER_PC, 32'h0000_4180, exception/interrupt entry address.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- Req  in  1  exception/interrupt taken (from CP0); redirect to HANDLER_PC.
- stall  in  1  hazard stall from the hazard unit; hold PC_F and the IF/ID register.
- eret_D  in  1  the instruction in D is ERET.
- EPC  in  32  ERET return address.
- npc_sel  in  1  branch taken or jump in D.
- npc_target  in  32  branch/jump target computed in D.
- jb_D  in  1  the instruction in D is any branch/jump (its successor is a delay slot).
- i_inst_rdata  in  32  instruction word from IM for i_inst_addr (combinational read).
- i_inst_addr  out  32  current fetch PC (PC_F).
- Instr_D  out  32  registered instruction word to the decode splitter.
- PC_D  out  32  registered PC of Instr_D.
- ExcCode_D  out  5  registered fetch exception code: 0 = none, 4 = AdEL.
- BD_D  out  1  Instr_D is in a branch delay slot.

Behaviour:
- Reset (asynchronous, any time, including mid-stall or mid-redirect):
  - PC_F = PC_RESET.
  - Instr_D = 0.
  - PC_D = PC_RESET.
  - ExcCode_D = 0.
  - BD_D = 0.
- i_inst_addr = PC_F combinationally. Instruction-memory latency is 0 cycles, so the instruction is captured into D on the same edge.
- AdEL_F = (PC_F[1:0] != 0) or (PC_F < IM_LO) or (PC_F > IM_HI). All comparisons are unsigned 32-bit.
- Instruction word captured into D: Instr_F = AdEL_F ? 0 : i_inst_rdata. A faulting fetch becomes a nop that carries code 4.
- Next-PC priority per edge, highest first:
  1. Req: PC_F <= HANDLER_PC. D <= {Instr 0, PC HANDLER_PC, ExcCode 0, BD 0}.
  2. stall: PC_F and all D registers hold. Req overrides stall in the same cycle.
  3. eret_D: PC_F <= EPC. D <= bubble {Instr 0, PC PC_F, ExcCode 0, BD 0}. ERET has no delay slot, so the word fetched after it is discarded.
  4. npc_sel: PC_F <= npc_target. D <= {Instr_F, PC_F, AdEL_F?4:0, BD 1}. The delay slot executes.
  5. Otherwise: PC_F <= PC_F + 4, wrapping mod 2^32. D <= {Instr_F, PC_F, AdEL_F?4:0, jb_D}.
- BD_D = jb_D at capture time whenever the fetch is not squashed. npc_sel implies jb_D.
- A bubble or Req flush always clears BD_D and ExcCode_D.
- PC_F never enters an undefined state. A misaligned npc_target or EPC is loaded as-is and faults on the next fetch.
- No combinational path exists from the stall/Req inputs to the D outputs. All D outputs are registered.

Test Plan:
- Reset, then release, 3 edges with IM returning 0x24010001, 0x24020002, 0x24030003 -> i_inst_addr steps 0x3000, 0x3004, 0x3008, 0x300C. Instr_D/PC_D lag one edge. ExcCode_D = 0 and BD_D = 0 throughout.
- stall held 2 cycles at PC_F = 0x3008 -> PC_F, Instr_D and PC_D unchanged both cycles. Sequential fetch resumes at 0x300C after release.
- Branch in D with jb_D = 1, npc_sel = 1, npc_target = 0x3100, PC_F = 0x3010 -> D gets PC 0x3010 with BD_D = 1. Next PC_F = 0x3100. The following capture has BD_D = 0.
- npc_target = 0x3102 -> next cycle AdEL_F. D gets Instr_D = 0, PC_D = 0x3102, ExcCode_D = 4. Repeat with target 0x7000 -> same, with PC_D = 0x7000.
- Req asserted together with stall at PC_F = 0x3020 -> PC_F = 0x4180, PC_D = 0x4180, Instr_D = 0, ExcCode_D = 0, BD_D = 0.
- eret_D = 1, EPC = 0x3040, PC_F = 0x4188 -> PC_F = 0x3040 and D is a bubble (Instr_D = 0). Then assert reset mid-cycle -> all outputs return to reset values immediately, before the next clock edge.
